bcd_down_timer: RTL

Multi-digit decimal (BCD) down-counter with parallel load, start/pause control and a terminal-count pulse. It complements the team's decimal up-counters: where those count 0→9 and wrap, this block loads a decimal value and counts down to zero. Used as a countdown timer or delay generator in simulation examples and small control designs, driving the same BCD display/monitor paths as the up-counters.

---
 rtl/bcd_down_timer_if.sv | 22 ++
 rtl/bcd_down_timer.sv | 85 ++++++++
 2 files changed

// File: rtl/bcd_down_timer_if.sv
// Control and status bundle for the BCD down timer: load/start/pause in, count and status out.
interface bcd_down_timer_if #(
  parameter int DIGITS = 2
);
  logic                  load;
  logic [4*DIGITS-1:0]   load_value;
  logic                  start;
  logic                  pause;
  logic [4*DIGITS-1:0]   cnt;
  logic                  running;
  logic                  done;

  modport master (
    output load, load_value, start, pause,
    input  cnt, running, done
  );

  modport slave (
    input  load, load_value, start, pause,
    output cnt, running, done
  );
endinterface

// File: rtl/bcd_down_timer.sv
// Multi-digit BCD down-counter with parallel load, start/pause control and a
// one-cycle terminal-count pulse when the count decrements to zero.
module bcd_down_timer #(
  parameter int DIGITS = 2
) (
  input  logic              clock,
  input  logic              reset,
  bcd_down_timer_if.slave   bus
);
  localparam int W = 4 * DIGITS;

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  state_t         state_p0, state_nxt;
  logic [W-1:0]   cnt_p0, cnt_nxt;
  logic           done_p0, done_nxt;

  // Digits above 9 saturate to 9 so the counter never holds a non-BCD digit.
  function automatic logic [W-1:0] bcd_clamp(input logic [W-1:0] v);
    logic [W-1:0] r;
    r = v;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
    end
    return r;
  endfunction

  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Priority: load > pause > start > counting; start while already running is a no-op.
  always_comb begin
    state_nxt = state_p0;
    cnt_nxt   = cnt_p0;
    done_nxt  = 1'b0;
    if (bus.load) begin
      cnt_nxt   = bcd_clamp(bus.load_value);
      state_nxt = IDLE;
    end else if (bus.pause) begin
      if (state_p0 == RUN) state_nxt = HOLD;
    end else if (bus.start && state_p0 != RUN) begin
      if (state_p0 == HOLD || cnt_p0 != '0) state_nxt = RUN;
    end else if (state_p0 == RUN) begin
      if (cnt_p0 == W'(1)) begin
        cnt_nxt   = '0;
        state_nxt = IDLE;
        done_nxt  = 1'b1;
      end else begin
        cnt_nxt = bcd_dec(cnt_p0);
      end
    end
  end

  // Stage p0: all state and outputs registered on the rising edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_p0 <= IDLE;
      cnt_p0   <= '0;
      done_p0  <= 1'b0;
    end else begin
      state_p0 <= state_nxt;
      cnt_p0   <= cnt_nxt;
      done_p0  <= done_nxt;
    end
  end

  assign bus.cnt     = cnt_p0;
  assign bus.running = (state_p0 == RUN);
  assign bus.done    = done_p0;
endmodule
